// File: rtl/radix4_seq_multiplier.sv
// Iterative radix-4 integer multiplier for the MUL/MULU path.
// Two multiplier bits are retired per cycle. The loop stops as soon as the
// remaining multiplier bits are all zero. A signed multiply runs on operand
// magnitudes, and the result sign is applied on the completion edge.
module radix4_seq_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   operand1,
    input  logic [WIDTH-1:0]   operand2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               sign_q;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic               res_sign;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_neg;

    // Operand conditioning: the magnitude of -2^(W-1) wraps to 2^(W-1), which is still correct
    always_comb begin
        mag1     = operand1;
        mag2     = operand2;
        res_sign = 1'b0;
        if (signed_mode) begin
            if (operand1[WIDTH-1]) mag1 = ~operand1 + WIDTH'(1);
            if (operand2[WIDTH-1]) mag2 = ~operand2 + WIDTH'(1);
            res_sign = operand1[WIDTH-1] ^ operand2[WIDTH-1];
        end
    end

    // Partial product for the current radix-4 digit, plus the negated accumulator for the sign fix
    always_comb begin
        pp = '0;
        case (mplier_q[1:0])
            2'b00:   pp = '0;
            2'b01:   pp = mcand_q;
            2'b10:   pp = mcand_q << 1;
            2'b11:   pp = mcand_q + (mcand_q << 1);
            default: pp = '0;
        endcase
        acc_neg = ~acc_q + (2 * WIDTH)'(1);
    end

    // Control FSM with registered busy/done/product; product is written only on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag1};
                        mplier_q <= mag2;
                        acc_q    <= '0;
                        sign_q   <= res_sign;
                        busy     <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (mplier_q != '0) begin
                        acc_q    <= acc_q + pp;
                        mcand_q  <= mcand_q << 2;
                        mplier_q <= mplier_q >> 2;
                    end else begin
                        product <= sign_q ? acc_neg : acc_q;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_seq_multiplier.sv
// Bench for radix4_seq_multiplier, with a 32-bit and an 8-bit instance.
// The expected products come from plain longint arithmetic.
// The expected latency comes from the bit length of the multiplier magnitude.
module tb_radix4_seq_multiplier;

    logic        clk;
    logic        rst;

    logic        start32, sm32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] prod32;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    int n_cmp;
    int n_bad;
    logic [63:0] hold32;
    logic [63:0] hold8;

    radix4_seq_multiplier #(.WIDTH(32)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .start       (start32),
        .signed_mode (sm32),
        .operand1    (a32),
        .operand2    (b32),
        .busy        (busy32),
        .done        (done32),
        .product     (prod32)
    );

    radix4_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_mode (sm8),
        .operand1    (a8),
        .operand2    (b8),
        .busy        (busy8),
        .done        (done8),
        .product     (prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // The golden product is the plain product of the operand values, truncated to 2*width bits
    function automatic logic [63:0] ref_prod(input bit w8, input logic [31:0] a,
                                             input logic [31:0] b, input bit sm);
        longint x, y, p;
        if (w8) begin
            x = sm ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            y = sm ? longint'($signed(b[7:0])) : longint'(b[7:0]);
            p = x * y;
            return {48'b0, p[15:0]};
        end
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p;
    endfunction

    // The expected latency is ceil(bit length of |operand2| / 2) + 2
    function automatic int ref_lat(input bit w8, input logic [31:0] b, input bit sm);
        logic [31:0] m;
        logic [7:0]  t8;
        int nb;
        if (w8) begin
            t8 = b[7:0];
            if (sm && t8[7]) t8 = 8'd0 - t8;
            m = {24'b0, t8};
        end else begin
            m = b;
            if (sm && m[31]) m = 32'd0 - m;
        end
        nb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) nb = i + 1;
        return (nb + 1) / 2 + 2;
    endfunction

    function automatic bit cur_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    function automatic bit cur_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    function automatic logic [63:0] cur_prod(input bit w8);
        return w8 ? {48'b0, prod8} : prod32;
    endfunction

    // Entered at a negedge; start is driven for the cycle that is about to end (cycle 0).
    // If restart_at != 0, a start with different operands is driven during that busy cycle.
    task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b,
                          input bit sm, input int restart_at, input string tag);
        logic [63:0] exp_p;
        logic [63:0] hold;
        int exp_lat, c, bad_busy, bad_hold;
        bit seen;
        exp_p   = ref_prod(w8, a, b, sm);
        exp_lat = ref_lat(w8, b, sm);
        hold    = w8 ? hold8 : hold32;
        if (w8) begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm;
        end else begin
            start32 = 1'b1; a32 = a; b32 = b; sm32 = sm;
        end
        @(negedge clk);
        c = 1; seen = 1'b0; bad_busy = 0; bad_hold = 0;
        while (c <= 40) begin
            if (cur_done(w8)) begin
                if (w8) start8 = 1'b0; else start32 = 1'b0;
                seen = 1'b1;
                break;
            end
            if (w8) begin
                start8 = (c == restart_at);
                if (c == restart_at) begin a8 = ~a[7:0]; b8 = b[7:0] ^ 8'h5A; sm8 = ~sm; end
            end else begin
                start32 = (c == restart_at);
                if (c == restart_at) begin a32 = ~a; b32 = b ^ 32'h5A5A_A5A5; sm32 = ~sm; end
            end
            if (!cur_busy(w8)) bad_busy++;
            if (cur_prod(w8) !== hold) bad_hold++;
            @(negedge clk);
            c++;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_product"}, cur_prod(w8), exp_p);
            check({tag, "_latency"}, 64'(c), 64'(exp_lat));
            check({tag, "_busy_at_done"}, 64'(cur_busy(w8)), 64'd0);
        end
        check({tag, "_busy_gaps"}, 64'(bad_busy), 64'd0);
        check({tag, "_product_held"}, 64'(bad_hold), 64'd0);
        if (w8) hold8 = exp_p; else hold32 = exp_p;
    endtask

    logic [7:0] corners [6];
    int n_done;

    initial begin
        n_cmp = 0; n_bad = 0;
        hold32 = '0; hold8 = '0;
        rst = 1'b1;
        start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;

        // Reset state, with start held high to show that reset takes priority
        repeat (3) @(negedge clk);
        start32 = 1'b1; a32 = 32'd5; b32 = 32'd7;
        @(negedge clk);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check("rst_prod32", prod32, 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_prod8", {48'b0, prod8}, 64'd0);
        start32 = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed cases; each op that follows a completion starts in the done cycle
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "umax");
        check("umax_exact", prod32, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        check("done_one_cycle", 64'(done32), 64'd0);
        check("prod_held_idle", prod32, 64'hFFFF_FFFE_0000_0001);
        run_op(1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 0, "s_m3x7");
        check("s_m3x7_exact", prod32, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, "s_minsq");
        check("s_minsq_exact", prod32, 64'h4000_0000_0000_0000);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, "u_minsq");
        run_op(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 0, "s_minx1");
        check("s_minx1_exact", prod32, 64'hFFFF_FFFF_8000_0000);
        run_op(1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0, 0, "zero");
        run_op(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 0, "b2b");
        run_op(1'b0, 32'h0000_1234, 32'hF00F_1234, 1'b0, 3, "restart");

        // Reset in cycle 3 of a k=16 operation aborts the operation without a done pulse
        @(negedge clk);
        start32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; sm32 = 1'b0;
        @(negedge clk);
        start32 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy32), 64'd0);
        check("abort_prod", prod32, 64'd0);
        hold32 = '0; hold8 = '0;
        n_done = 0;
        for (int i = 0; i < 24; i++) begin
            if (done32) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(n_done), 64'd0);

        // Random 32-bit operations with varied multiplier lengths
        for (int i = 0; i < 150; i++) begin
            run_op(1'b0, $urandom, $urandom >> $urandom_range(0, 31),
                   1'($urandom_range(0, 1)), (i % 10 == 0) ? 2 : 0, "rand32");
        end

        // 8-bit instance: all corner pairs in both modes, then random operands
        corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
        corners[3] = 8'h80; corners[4] = 8'h81; corners[5] = 8'hFF;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    run_op(1'b1, {24'b0, corners[i]}, {24'b0, corners[j]}, 1'(m), 0, "corner8");
                end
            end
        end
        for (int i = 0; i < 1500; i++) begin
            run_op(1'b1, {24'b0, 8'($urandom)}, {24'b0, 8'($urandom)},
                   1'($urandom_range(0, 1)), 0, "rand8");
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
